// File: rtl/data_memory_if.sv
// data_memory_if: requester-side request/response bus of data_memory.
//   addr        word address of request
//   data_write  write data
//   read_en     read request, sampled each cycle
//   write_en    write request, sampled each cycle (wins over read_en)
//   data_read   read result, held until the next completed read
// master: processor datapath side; slave: data_memory side.
interface data_memory_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_write;
  logic              read_en;
  logic              write_en;
  logic [DATA_W-1:0] data_read;

  modport master (
    output addr,
    output data_write,
    output read_en,
    output write_en,
    input  data_read
  );

  modport slave (
    input  addr,
    input  data_write,
    input  read_en,
    input  write_en,
    output data_read
  );
endinterface

// File: rtl/data_memory.sv
// data_memory: word-addressed data memory. A front end registers each
// request onto an internal memory bus; a controller services that bus from
// a MEM_SIZE x MEM_WIDTH synchronous array. Read latency is 3 cycles from
// request to data_read; one request is accepted every cycle.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset (array contents kept)
//   req           data_memory_if.slave request/response bus
//   mem_addr      internal bus address, zero-extended registered addr
//   mem_read_en   internal bus read strobe
//   mem_write_en  internal bus write strobe
//   mem_write_val internal bus write data
//   mem_read_val  controller array output
// MEM_WIDTH must equal 32 (front-end data ports are fixed at 32 bits).
module data_memory #(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned MEM_SIZE  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  data_memory_if.slave         req,
  output logic [31:0]          mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [31:0]          mem_write_val,
  output logic [MEM_WIDTH-1:0] mem_read_val
);

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned IDX_W  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [MEM_WIDTH-1:0] mem_array [MEM_SIZE];

  logic             read_pending;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;

  // ---------------------------------------------------------------------
  // Front end: register request onto the internal bus; write beats read.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr      <= '0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      mem_write_val <= '0;
    end else begin
      mem_addr      <= {(BUS_W - ADDR_W)'(0), req.addr};
      mem_read_en   <= req.read_en & ~req.write_en;
      mem_write_en  <= req.write_en;
      mem_write_val <= req.data_write;
    end
  end

  // Front end return: capture the array output one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_pending   <= 1'b0;
      req.data_read  <= '0;
    end else begin
      read_pending <= mem_read_en;
      if (read_pending) begin
        req.data_read <= BUS_W'(mem_read_val);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Controller: address decode for the array.
  // ---------------------------------------------------------------------
  always_comb begin
    in_range_c = (mem_addr < BUS_W'(MEM_SIZE));
    idx_c      = mem_addr[IDX_W-1:0];
  end

  // Array write; a write on the bus during a reset cycle is discarded.
  // No reset on the array: contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && mem_write_en && in_range_c) begin
      mem_array[idx_c] <= MEM_WIDTH'(mem_write_val);
    end
  end

  // Array read; out-of-range reads return zero, idle cycles hold the value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read_val <= '0;
    end else if (mem_read_en) begin
      if (in_range_c) begin
        mem_read_val <= mem_array[idx_c];
      end else begin
        mem_read_val <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed, self-checking bench for data_memory (MEM_SIZE=16).
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_write_val;
  logic [31:0] mem_read_val;

  int unsigned n_checks;
  int unsigned n_fail;

  data_memory_if bus ();

  data_memory #(
    .MEM_WIDTH (32),
    .MEM_SIZE  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (bus),
    .mem_addr      (mem_addr),
    .mem_read_en   (mem_read_en),
    .mem_write_en  (mem_write_en),
    .mem_write_val (mem_write_val),
    .mem_read_val  (mem_read_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.addr       = '0;
    bus.data_write = '0;
    bus.read_en    = 1'b0;
    bus.write_en   = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    bus.addr       = a;
    bus.data_write = d;
    bus.write_en   = 1'b1;
    bus.read_en    = 1'b0;
    tick();
    idle();
  endtask

  // Present a read and return data_read after the 3-cycle latency.
  task automatic do_read(input logic [7:0] a, output logic [31:0] d);
    bus.addr     = a;
    bus.read_en  = 1'b1;
    bus.write_en = 1'b0;
    tick();
    idle();
    tick();
    tick();
    d = bus.data_read;
  endtask

  logic [31:0] rd;

  initial begin
    clk      = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();

    // Reset then idle.
    tick();
    tick();
    rst = 1'b0;
    check("rst_data_read", bus.data_read, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_read_en", 32'(mem_read_en), 32'h0);
    check("rst_mem_write_en", 32'(mem_write_en), 32'h0);
    check("rst_mem_write_val", mem_write_val, 32'h0);
    check("rst_mem_read_val", mem_read_val, 32'h0);
    tick();
    tick();
    check("idle_data_read", bus.data_read, 32'h0);
    check("idle_mem_read_val", mem_read_val, 32'h0);

    // Write addr 0 = 1, then read it back.
    do_write(8'd0, 32'h1);
    check("wr0_mem_write_en", 32'(mem_write_en), 32'h1);
    check("wr0_mem_write_val", mem_write_val, 32'h1);
    check("wr0_mem_addr", mem_addr, 32'h0);
    tick();
    bus.addr    = 8'd0;
    bus.read_en = 1'b1;
    tick();
    idle();
    check("rd0_mem_read_en", 32'(mem_read_en), 32'h1);
    tick();
    check("rd0_mem_read_val", mem_read_val, 32'h1);
    tick();
    check("rd0_data_read", bus.data_read, 32'h1);

    // Back-to-back writes then back-to-back reads.
    do_write(8'd5, 32'hDEADBEEF);
    do_write(8'd6, 32'h12345678);
    bus.addr    = 8'd5;
    bus.read_en = 1'b1;
    tick();
    bus.addr    = 8'd6;
    tick();
    idle();
    check("b2b_mem_read_val", mem_read_val, 32'hDEADBEEF);
    tick();
    check("b2b_data_read_5", bus.data_read, 32'hDEADBEEF);
    tick();
    check("b2b_data_read_6", bus.data_read, 32'h12345678);

    // Read-after-write to the same address in the next cycle.
    bus.addr       = 8'd7;
    bus.data_write = 32'hA5A5A5A5;
    bus.write_en   = 1'b1;
    tick();
    bus.write_en   = 1'b0;
    bus.data_write = '0;
    bus.read_en    = 1'b1;
    tick();
    idle();
    tick();
    check("raw_hold", bus.data_read, 32'h12345678);
    tick();
    check("raw_data_read", bus.data_read, 32'hA5A5A5A5);

    // Collision: write wins, no read performed.
    bus.addr       = 8'd9;
    bus.data_write = 32'h55;
    bus.read_en    = 1'b1;
    bus.write_en   = 1'b1;
    tick();
    idle();
    check("coll_mem_read_en", 32'(mem_read_en), 32'h0);
    check("coll_mem_write_en", 32'(mem_write_en), 32'h1);
    tick();
    tick();
    tick();
    check("coll_data_read_hold", bus.data_read, 32'hA5A5A5A5);
    do_read(8'd9, rd);
    check("coll_readback", rd, 32'h55);

    // Out-of-range write dropped, read returns zero.
    do_write(8'd20, 32'hFF);
    check("oor_mem_addr", mem_addr, 32'd20);
    tick();
    do_read(8'd20, rd);
    check("oor_read", rd, 32'h0);

    // Top in-range address.
    do_write(8'd15, 32'hCAFEF00D);
    tick();
    do_read(8'd15, rd);
    check("top_read", rd, 32'hCAFEF00D);

    // Reset between a read request and its return cancels it.
    bus.addr    = 8'd15;
    bus.read_en = 1'b1;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_cancel_now", bus.data_read, 32'h0);
    check("rst_cancel_rval", mem_read_val, 32'h0);
    tick();
    tick();
    check("rst_cancel_later", bus.data_read, 32'h0);
    do_read(8'd15, rd);
    check("post_rst_read", rd, 32'hCAFEF00D);

    // A write already on the bus during reset is discarded.
    do_write(8'd3, 32'h11);
    tick();
    do_write(8'd3, 32'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_read(8'd3, rd);
    check("rst_drop_write", rd, 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
